// File: rtl/proc_mem_arb_pkg.sv
// Shared message layouts and constants for the two-port to one-port memory arbiter.
package proc_mem_arb_pkg;

    localparam int REQ_W  = 65;
    localparam int RESP_W = 33;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic TAG_IMEM = 1'b0;
    localparam logic TAG_DMEM = 1'b1;

    typedef struct packed {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        logic        typ;
        logic [31:0] data;
    } mem_resp_t;

    function automatic logic req_tag(input logic dmem_granted);
        return dmem_granted ? TAG_DMEM : TAG_IMEM;
    endfunction

endpackage

// File: rtl/proc_mem_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight memory request.
module proc_mem_arb_tag_fifo
    import proc_mem_arb_pkg::*;
#(
    parameter int P_DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  logic i_push_tag,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CW = $clog2(P_DEPTH + 1);

    logic [P_DEPTH-1:0] r_tags;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(P_DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(P_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_tags[r_rd_ptr];

    // Guard against protocol misuse; a full FIFO never takes a push even if it pops.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= i_push_tag;
                r_wr_ptr         <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/proc_mem_arb.sv
// Shares one memory port between imem (port 0) and dmem (port 1); dmem has fixed
// priority and in-order responses are steered back using the tag FIFO.
module proc_mem_arb
    import proc_mem_arb_pkg::*;
#(
    parameter int p_num_outstanding = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_imemreq_val,
    output logic              o_imemreq_rdy,
    input  logic [REQ_W-1:0]  i_imemreq_msg,
    output logic              o_imemresp_val,
    input  logic              i_imemresp_rdy,
    output logic [RESP_W-1:0] o_imemresp_msg,

    input  logic              i_dmemreq_val,
    output logic              o_dmemreq_rdy,
    input  logic [REQ_W-1:0]  i_dmemreq_msg,
    output logic              o_dmemresp_val,
    input  logic              i_dmemresp_rdy,
    output logic [RESP_W-1:0] o_dmemresp_msg,

    output logic              o_memreq_val,
    input  logic              i_memreq_rdy,
    output logic [REQ_W-1:0]  o_memreq_msg,
    input  logic              i_memresp_val,
    output logic              o_memresp_rdy,
    input  logic [RESP_W-1:0] i_memresp_msg
);

    mem_req_t  w_imem_req;
    mem_req_t  w_dmem_req;
    mem_resp_t w_mem_resp;

    logic w_live;
    logic w_grant_d;
    logic w_grant_i;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_req_xfer;
    logic w_resp_xfer;

    assign w_imem_req = i_imemreq_msg;
    assign w_dmem_req = i_dmemreq_msg;
    assign w_mem_resp = i_memresp_msg;

    // Every handshake output is held low while reset is asserted.
    assign w_live = ~i_rst;

    assign w_grant_d = i_dmemreq_val;
    assign w_grant_i = i_imemreq_val & ~i_dmemreq_val;

    // Request side depends only on registered FIFO state, never on any resp_rdy.
    assign o_memreq_val  = w_live & (i_imemreq_val | i_dmemreq_val) & ~w_full;
    assign o_dmemreq_rdy = w_live & w_grant_d & i_memreq_rdy & ~w_full;
    assign o_imemreq_rdy = w_live & w_grant_i & i_memreq_rdy & ~w_full;
    assign o_memreq_msg  = w_grant_d ? w_dmem_req : w_imem_req;

    assign w_req_xfer = o_memreq_val & i_memreq_rdy;

    assign o_imemresp_val = w_live & i_memresp_val & ~w_empty & (w_head == TAG_IMEM);
    assign o_dmemresp_val = w_live & i_memresp_val & ~w_empty & (w_head == TAG_DMEM);
    assign o_memresp_rdy  = w_live & ~w_empty &
                            ((w_head == TAG_DMEM) ? i_dmemresp_rdy : i_imemresp_rdy);
    assign o_imemresp_msg = w_mem_resp;
    assign o_dmemresp_msg = w_mem_resp;

    assign w_resp_xfer = i_memresp_val & o_memresp_rdy;

    proc_mem_arb_tag_fifo #(
        .P_DEPTH (p_num_outstanding)
    ) u_tag_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_req_xfer),
        .i_push_tag (req_tag(w_grant_d)),
        .i_pop      (w_resp_xfer),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    // A response with nothing in flight has no owner and is left unacknowledged.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_memresp_val && w_empty))
                else $error("proc_mem_arb: memresp_val asserted with no request in flight");
        end
    end

endmodule

// File: tb/tb_proc_mem_arb.sv
// Directed and randomized checks of proc_mem_arb against a queue-based reference model.
module tb_proc_mem_arb;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        iv, dv, mrdy, irr, drr, mresp_go;
    logic [64:0] imsg, dmsg;

    logic        i_memresp_val;
    logic [32:0] i_memresp_msg;

    logic        o_imemreq_rdy, o_dmemreq_rdy, o_imemresp_val, o_dmemresp_val;
    logic        o_memreq_val, o_memresp_rdy;
    logic [32:0] o_imemresp_msg, o_dmemresp_msg;
    logic [64:0] o_memreq_msg;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    bit          tq[$];
    logic [32:0] pend[$];
    logic [32:0] iexp[$];
    logic [32:0] dexp[$];
    logic [31:0] mem[logic [31:0]];

    logic e_full, e_empty, e_head, e_mval, e_irdy, e_drdy, e_iresp, e_dresp, e_mrr;

    proc_mem_arb #(.p_num_outstanding(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_imemreq_val  (iv),
        .o_imemreq_rdy  (o_imemreq_rdy),
        .i_imemreq_msg  (imsg),
        .o_imemresp_val (o_imemresp_val),
        .i_imemresp_rdy (irr),
        .o_imemresp_msg (o_imemresp_msg),
        .i_dmemreq_val  (dv),
        .o_dmemreq_rdy  (o_dmemreq_rdy),
        .i_dmemreq_msg  (dmsg),
        .o_dmemresp_val (o_dmemresp_val),
        .i_dmemresp_rdy (drr),
        .o_dmemresp_msg (o_dmemresp_msg),
        .o_memreq_val   (o_memreq_val),
        .i_memreq_rdy   (mrdy),
        .o_memreq_msg   (o_memreq_msg),
        .i_memresp_val  (i_memresp_val),
        .o_memresp_rdy  (o_memresp_rdy),
        .i_memresp_msg  (i_memresp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic mem_access(input logic [64:0] req, output logic [32:0] resp);
        if (req[64]) begin
            mem[req[63:32]] = req[31:0];
            resp = {1'b1, 32'h0};
        end else if (mem.exists(req[63:32])) begin
            resp = {1'b0, mem[req[63:32]]};
        end else begin
            resp = {1'b0, req[63:32] ^ 32'h5A5A_A5A5};
        end
    endtask

    // Drive the memory side, let combinational paths settle, compare against the model.
    task automatic settle();
        i_memresp_val = !rst && mresp_go && (pend.size() > 0);
        i_memresp_msg = (pend.size() > 0) ? pend[0] : 33'($urandom);
        #2;
        e_full  = (tq.size() >= DEPTH);
        e_empty = (tq.size() == 0);
        e_head  = e_empty ? 1'b0 : tq[0];
        e_mval  = !rst && (iv || dv) && !e_full;
        e_drdy  = !rst && dv && mrdy && !e_full;
        e_irdy  = !rst && iv && !dv && mrdy && !e_full;
        e_iresp = !rst && i_memresp_val && !e_empty && !e_head;
        e_dresp = !rst && i_memresp_val && !e_empty && e_head;
        e_mrr   = !rst && !e_empty && (e_head ? drr : irr);
        chk("memreq_val",   o_memreq_val,   e_mval);
        chk("imemreq_rdy",  o_imemreq_rdy,  e_irdy);
        chk("dmemreq_rdy",  o_dmemreq_rdy,  e_drdy);
        chk("memreq_msg",   o_memreq_msg,   dv ? dmsg : imsg);
        chk("imemresp_val", o_imemresp_val, e_iresp);
        chk("dmemresp_val", o_dmemresp_val, e_dresp);
        chk("memresp_rdy",  o_memresp_rdy,  e_mrr);
        if (e_iresp && irr && iexp.size() > 0) chk("imemresp_data", o_imemresp_msg, iexp[0]);
        if (e_dresp && drr && dexp.size() > 0) chk("dmemresp_data", o_dmemresp_msg, dexp[0]);
    endtask

    task automatic advance();
        logic [32:0] r;
        if (rst) begin
            tq.delete(); pend.delete(); iexp.delete(); dexp.delete();
        end else begin
            if (i_memresp_val && e_mrr) begin
                if (e_head) void'(dexp.pop_front());
                else        void'(iexp.pop_front());
                void'(tq.pop_front());
                void'(pend.pop_front());
            end
            if (e_mval && mrdy) begin
                mem_access(dv ? dmsg : imsg, r);
                tq.push_back(dv);
                pend.push_back(r);
                if (dv) dexp.push_back(r);
                else    iexp.push_back(r);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic drain();
        iv = 0; dv = 0; mresp_go = 1; irr = 1; drr = 1;
        for (int k = 0; k < 20 && pend.size() > 0; k++) cycle();
        chk("drain_empty", 65'(pend.size()), 65'd0);
    endtask

    initial begin
        rst = 1; iv = 1; dv = 1; mrdy = 1; irr = 1; drr = 1; mresp_go = 0;
        imsg = '0; dmsg = '0;
        i_memresp_val = 0; i_memresp_msg = '0;

        // reset: every handshake output low even with requests pending
        settle();
        chk("rst_memreq_val", o_memreq_val, 1'b0);
        chk("rst_dmemreq_rdy", o_dmemreq_rdy, 1'b0);
        advance();
        rst = 0; iv = 0; dv = 0;

        // single imem read of 0x200 returning 0xDEADBEEF
        mem[32'h200] = 32'hDEAD_BEEF;
        imsg = {1'b0, 32'h200, 32'h0};
        iv = 1;
        cycle();
        iv = 0; mresp_go = 1;
        settle();
        chk("t1_iresp_val", o_imemresp_val, 1'b1);
        chk("t1_iresp_msg", o_imemresp_msg, {1'b0, 32'hDEAD_BEEF});
        chk("t1_dresp_val", o_dmemresp_val, 1'b0);
        advance();

        // simultaneous imem read and dmem write: dmem first, responses in order
        mresp_go = 0;
        iv = 1; imsg = {1'b0, 32'h100, 32'h0};
        dv = 1; dmsg = {1'b1, 32'h100, 32'h5};
        settle();
        chk("t2_dgrant", o_dmemreq_rdy, 1'b1);
        chk("t2_imem_wait", o_imemreq_rdy, 1'b0);
        chk("t2_fwd_msg", o_memreq_msg, {1'b1, 32'h100, 32'h5});
        advance();
        dv = 0;
        settle();
        chk("t2_igrant", o_imemreq_rdy, 1'b1);
        advance();
        iv = 0; mresp_go = 1;
        settle();
        chk("t2_dack", o_dmemresp_val, 1'b1);
        advance();
        settle();
        chk("t2_idata_val", o_imemresp_val, 1'b1);
        chk("t2_idata", o_imemresp_msg, {1'b0, 32'h5});
        advance();

        // downstream stall with both ports valid
        iv = 1; dv = 1; mrdy = 0; mresp_go = 0;
        repeat (3) begin
            settle();
            chk("t3_memreq_val", o_memreq_val, 1'b1);
            advance();
        end
        dv = 0; mrdy = 1;

        // fill to depth, blocked while full, accepted the cycle after a pop
        imsg = {1'b0, 32'h40, 32'h0};
        cycle();
        cycle();
        settle();
        chk("t4_full_blocks", o_imemreq_rdy, 1'b0);
        advance();
        mresp_go = 1; irr = 1;
        settle();
        chk("t4_full_pop_blocks", o_imemreq_rdy, 1'b0);
        advance();
        settle();
        chk("t4_after_pop", o_imemreq_rdy, 1'b1);
        advance();
        for (int k = 0; k < 10; k++) begin
            imsg = {1'b0, 32'(k * 4), 32'h0};
            cycle();
        end
        drain();

        // dmem head response stalled by dmemresp_rdy; must not leak to imem
        dv = 1; dmsg = {1'b0, 32'h80, 32'h0}; mresp_go = 0;
        cycle();
        dv = 0; mresp_go = 1; drr = 0; irr = 1;
        repeat (2) begin
            settle();
            chk("t5_memresp_rdy", o_memresp_rdy, 1'b0);
            chk("t5_no_misroute", o_imemresp_val, 1'b0);
            advance();
        end
        drr = 1;
        cycle();

        // reset with two requests outstanding
        iv = 1; mresp_go = 0; imsg = {1'b0, 32'h300, 32'h0};
        cycle();
        cycle();
        rst = 1; iv = 0;
        cycle();
        rst = 0;
        settle();
        chk("t6_empty_rdy", o_memresp_rdy, 1'b0);
        chk("t6_accept", o_memreq_val, 1'b0);
        advance();
        iv = 1; imsg = {1'b0, 32'h200, 32'h0};
        cycle();
        iv = 0; mresp_go = 1;
        settle();
        chk("t6_fresh_read", o_imemresp_msg, {1'b0, 32'hDEAD_BEEF});
        advance();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            iv = ($urandom_range(0, 1) != 0);
            dv = ($urandom_range(0, 2) == 0);
            mrdy = ($urandom_range(0, 3) != 0);
            irr = ($urandom_range(0, 3) != 0);
            drr = ($urandom_range(0, 3) != 0);
            mresp_go = ($urandom_range(0, 2) != 0);
            imsg = {($urandom_range(0, 1) != 0), 26'd0, 4'($urandom_range(0, 15)), 2'b00, 32'($urandom)};
            dmsg = {($urandom_range(0, 1) != 0), 26'd0, 4'($urandom_range(0, 15)), 2'b00, 32'($urandom)};
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
